// File: rtl/eth_tx_scheduler.sv
// Ethernet TX frame scheduler: arbitrates ARP / motor / AD frames, issues one
// command at a time to the frame builder, then enforces watchdog and inter-frame gap.
module eth_tx_scheduler #(
  parameter int                            C_AXI_ADDR_WIDTH = 32,
  parameter logic [C_AXI_ADDR_WIDTH-1:0]   C_ADDR_MOTOR2ETH = 32'h0000_0000,
  parameter logic [C_AXI_ADDR_WIDTH-1:0]   C_ADDR_AD2ETH    = 32'h1000_0000,
  parameter logic [C_AXI_ADDR_WIDTH-1:0]   C_ADDR_SUMOFFSET = 32'h0000_1000,
  parameter int                            NUM_SLOTS        = 8,
  parameter int                            IFG_CYCLES       = 12,
  parameter int                            WATCH_DOG_WIDTH  = 12
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        trig_arp,
  input  logic                        trig_package_rst,
  input  logic                        req_motor,
  input  logic                        req_ad,
  output logic                        tx_cmd_valid,
  input  logic                        tx_cmd_ready,
  output logic [1:0]                  tx_cmd_sel,
  output logic [C_AXI_ADDR_WIDTH-1:0] tx_cmd_addr,
  input  logic                        tx_done,
  output logic                        tx_abort,
  output logic                        grant_motor,
  output logic                        grant_ad,
  output logic                        busy,
  output logic [7:0]                  timeout_cnt
);

  // state     | meaning
  // IDLE      | waiting for ARP / motor / AD request
  // CMD       | command presented, waiting for tx_cmd_ready
  // WAIT_DONE | frame in flight, watchdog running
  // GAP       | inter-frame gap countdown

  localparam int AW     = C_AXI_ADDR_WIDTH;
  localparam int PTR_W  = $clog2(NUM_SLOTS);
  localparam int WD_W   = WATCH_DOG_WIDTH;
  localparam int GAP_W  = $clog2(IFG_CYCLES + 1);
  // Down-counter terminal at 0 after 2^W-1 cycles in WAIT_DONE.
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'((1 << WD_W) - 2);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_MOTOR = 2'b01;
  localparam logic [1:0] SEL_AD    = 2'b10;
  localparam logic [1:0] SEL_ARP   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT_DONE, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sel_q, pick_sel;
  logic [AW-1:0]     addr_q, pick_addr;
  logic [PTR_W-1:0]  motor_ptr, ad_ptr;
  logic              last_ad;
  logic              arp_pending;
  logic [WD_W-1:0]   wd_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              accept;
  logic              wd_expire;
  logic [AW-1:0]     motor_addr, ad_addr;

  assign motor_addr = C_ADDR_MOTOR2ETH + AW'(motor_ptr) * C_ADDR_SUMOFFSET;
  assign ad_addr    = C_ADDR_AD2ETH + AW'(ad_ptr) * C_ADDR_SUMOFFSET;
  assign accept     = (state_q == S_CMD) && tx_cmd_ready;
  assign wd_expire  = (state_q == S_WAIT_DONE) && (wd_cnt == '0) && !tx_done;

  always_comb begin
    state_d   = state_q;
    pick_sel  = SEL_NONE;
    pick_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (arp_pending) begin
          pick_sel = SEL_ARP;
        end else if (req_motor && (!req_ad || last_ad)) begin
          pick_sel  = SEL_MOTOR;
          pick_addr = motor_addr;
        end else if (req_ad) begin
          pick_sel  = SEL_AD;
          pick_addr = ad_addr;
        end
        if (pick_sel != SEL_NONE) state_d = S_CMD;
      end
      S_CMD:       if (accept) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_done || wd_expire) state_d = S_GAP;
      S_GAP:       if (gap_cnt == '0) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      sel_q       <= SEL_NONE;
      addr_q      <= '0;
      motor_ptr   <= '0;
      ad_ptr      <= '0;
      last_ad     <= 1'b1;
      arp_pending <= 1'b0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      timeout_cnt <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && state_d == S_CMD) begin
        sel_q  <= pick_sel;
        addr_q <= pick_addr;
      end

      // A new trigger in the accept cycle must survive the clear.
      arp_pending <= trig_arp | (arp_pending & !(accept && sel_q == SEL_ARP));

      if (trig_package_rst) begin
        motor_ptr <= '0;
        ad_ptr    <= '0;
      end else if (accept && sel_q == SEL_MOTOR) begin
        motor_ptr <= motor_ptr + 1'b1;
      end else if (accept && sel_q == SEL_AD) begin
        ad_ptr <= ad_ptr + 1'b1;
      end

      if (accept && sel_q == SEL_MOTOR) last_ad <= 1'b0;
      else if (accept && sel_q == SEL_AD) last_ad <= 1'b1;

      if (accept) wd_cnt <= WD_LOAD;
      else if (state_q == S_WAIT_DONE && wd_cnt != '0) wd_cnt <= wd_cnt - 1'b1;

      if (state_q != S_GAP) gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

      if (wd_expire && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  assign tx_cmd_valid = (state_q == S_CMD);
  assign tx_cmd_sel   = (state_q == S_CMD) ? sel_q : SEL_NONE;
  assign tx_cmd_addr  = (state_q == S_CMD) ? addr_q : '0;
  assign grant_motor  = accept && (sel_q == SEL_MOTOR);
  assign grant_ad     = accept && (sel_q == SEL_AD);
  assign tx_abort     = wd_expire;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler: arbitration, addressing, turnaround,
// watchdog, pointer reset race and async reset.
module tb_eth_tx_scheduler;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        trig_arp = 1'b0;
  logic        trig_package_rst = 1'b0;
  logic        req_motor = 1'b0;
  logic        req_ad = 1'b0;
  logic        tx_cmd_valid;
  logic        tx_cmd_ready = 1'b1;
  logic [1:0]  tx_cmd_sel;
  logic [31:0] tx_cmd_addr;
  logic        tx_done = 1'b0;
  logic        tx_abort;
  logic        grant_motor;
  logic        grant_ad;
  logic        busy;
  logic [7:0]  timeout_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc = 0;

  eth_tx_scheduler dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .trig_arp(trig_arp),
    .trig_package_rst(trig_package_rst), .req_motor(req_motor), .req_ad(req_ad),
    .tx_cmd_valid(tx_cmd_valid), .tx_cmd_ready(tx_cmd_ready), .tx_cmd_sel(tx_cmd_sel),
    .tx_cmd_addr(tx_cmd_addr), .tx_done(tx_done), .tx_abort(tx_abort),
    .grant_motor(grant_motor), .grant_ad(grant_ad), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for tx_cmd_valid at a negedge and checks the command.
  task automatic expect_cmd(input string tag, input logic [1:0] sel, input logic [31:0] addr);
    int n = 0;
    while (!tx_cmd_valid && n < 60) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, "_valid"}, 64'(tx_cmd_valid), 64'd1);
    check({tag, "_sel"}, 64'(tx_cmd_sel), 64'(sel));
    check({tag, "_addr"}, 64'(tx_cmd_addr), 64'(addr));
    check({tag, "_gm"}, 64'(grant_motor), 64'(sel == 2'b01));
    check({tag, "_ga"}, 64'(grant_ad), 64'(sel == 2'b10));
  endtask

  // Called in the accept cycle: tx_done 5 cycles later.
  task automatic finish_frame();
    repeat (5) @(negedge sys_clk);
    tx_done = 1'b1;
    done_cyc = cyc;
    @(negedge sys_clk);
    tx_done = 1'b0;
  endtask

  initial begin
    int n;
    @(negedge sys_clk);
    check("rst_valid", 64'(tx_cmd_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_abort", 64'(tx_abort), 64'd0);
    check("rst_tocnt", 64'(timeout_cnt), 64'd0);
    check("rst_addr", 64'(tx_cmd_addr), 64'd0);
    sys_rst = 1'b0;

    // Motor only: eight slots then wrap, 14-cycle turnaround after tx_done.
    @(negedge sys_clk);
    req_motor = 1'b1;
    for (int i = 0; i < 9; i++) begin
      expect_cmd("motor", 2'b01, 32'((i % 8) * 32'h1000));
      if (i > 0) check("turnaround", 64'(cyc - done_cyc), 64'd14);
      if (i == 8) req_motor = 1'b0;
      finish_frame();
      if (i == 0) check("busy_gap", 64'(busy), 64'd1);
    end
    @(negedge sys_clk);
    req_motor = 1'b1;
    expect_cmd("motor_next", 2'b01, 32'h0000_1000);
    @(negedge sys_clk);
    req_motor = 1'b0;
    check("drop_valid", 64'(tx_cmd_valid), 64'd0);
    check("drop_sel", 64'(tx_cmd_sel), 64'd0);
    check("drop_addr", 64'(tx_cmd_addr), 64'd0);

    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Round-robin from reset: motor wins the first tie.
    req_motor = 1'b1;
    req_ad = 1'b1;
    expect_cmd("rr0", 2'b01, 32'h0000_0000);
    finish_frame();
    expect_cmd("rr1", 2'b10, 32'h1000_0000);
    finish_frame();
    expect_cmd("rr2", 2'b01, 32'h0000_1000);
    finish_frame();
    expect_cmd("rr3", 2'b10, 32'h1000_1000);
    req_ad = 1'b0;
    finish_frame();

    // ARP priority and collapse of repeated triggers.
    expect_cmd("arp_pre", 2'b01, 32'h0000_2000);
    req_ad = 1'b1;
    @(negedge sys_clk); trig_arp = 1'b1;
    @(negedge sys_clk); trig_arp = 1'b0;
    @(negedge sys_clk); trig_arp = 1'b1;
    @(negedge sys_clk); trig_arp = 1'b0;
    @(negedge sys_clk); tx_done = 1'b1;
    @(negedge sys_clk); tx_done = 1'b0;
    expect_cmd("arp", 2'b11, 32'h0000_0000);
    finish_frame();
    expect_cmd("arp_post", 2'b10, 32'h1000_2000);
    req_ad = 1'b0;
    finish_frame();

    // Pointer reset coinciding with a motor accept at motor_ptr=3.
    expect_cmd("race", 2'b01, 32'h0000_3000);
    trig_package_rst = 1'b1;
    @(negedge sys_clk);
    trig_package_rst = 1'b0;
    repeat (4) @(negedge sys_clk);
    tx_done = 1'b1;
    @(negedge sys_clk);
    tx_done = 1'b0;
    expect_cmd("race_next", 2'b01, 32'h0000_0000);
    req_motor = 1'b0;

    // Watchdog: no tx_done on this frame.
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!tx_abort && n < 5000);
    check("wd_latency", 64'(n), 64'd4095);
    check("wd_cnt_before", 64'(timeout_cnt), 64'd0);
    @(negedge sys_clk);
    check("wd_abort_pulse", 64'(tx_abort), 64'd0);
    check("wd_cnt_after", 64'(timeout_cnt), 64'd1);
    n = 1;
    while (busy && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    check("wd_to_idle", 64'(n), 64'd13);

    tx_done = 1'b1;
    @(negedge sys_clk);
    tx_done = 1'b0;
    check("done_in_idle", 64'(busy), 64'd0);

    // tx_done on the expiry cycle is a normal completion.
    req_motor = 1'b1;
    expect_cmd("wd_race", 2'b01, 32'h0000_1000);
    req_motor = 1'b0;
    repeat (4095) @(negedge sys_clk);
    tx_done = 1'b1;
    #1;
    check("wd_race_abort", 64'(tx_abort), 64'd0);
    @(negedge sys_clk);
    tx_done = 1'b0;
    check("wd_race_cnt", 64'(timeout_cnt), 64'd1);
    check("wd_race_gap", 64'(busy), 64'd1);
    repeat (14) @(negedge sys_clk);

    // Async reset mid-frame.
    req_motor = 1'b1;
    expect_cmd("arst_pre", 2'b01, 32'h0000_2000);
    repeat (2) @(negedge sys_clk);
    check("arst_busy_pre", 64'(busy), 64'd1);
    sys_rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_tocnt", 64'(timeout_cnt), 64'd0);
    check("arst_valid", 64'(tx_cmd_valid), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    expect_cmd("arst_post", 2'b01, 32'h0000_0000);
    req_motor = 1'b0;
    finish_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
